polyphase_interp_pipe: RTL and testbench

//  Synthesizable polyphase fractional-delay interpolator for I/Q.
//  - Sits in the MSK demod timing-recovery loop: raw ADC-rate I/Q in, one interpolated I/Q pair out per symbol strobe.
//  - Phase bank is selected by the timing loop's integer phase.
//  - Each output uses TAPS_PPH time-multiplexed MACs per channel against a ROM coefficient bank.
//  - Adds overrun/phase-error status and a bypass mode.

---
 rtl/interp_pkg.sv | 55 +++++
 rtl/interp_sample_ram.sv | 30 +++
 rtl/polyphase_interp_pipe.sv | 178 +++++++++++++++++
 tb/tb_polyphase_interp_pipe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared types, sizing and the polyphase coefficient bank for the I/Q interpolator.
// Each branch sums to 32768, so the DC gain is exactly one.
package interp_pkg;

   localparam int OSF      = 20;
   localparam int TAPS_PPH = 5;
   localparam int WIQ      = 16;
   localparam int COEF_W   = 16;
   localparam int WO       = 18;
   localparam int ACC_W    = WIQ + COEF_W + $clog2(TAPS_PPH);
   localparam int DEPTH    = OSF * (TAPS_PPH + 1);
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int TAP_W    = $clog2(TAPS_PPH + 1);

   typedef logic signed [WIQ-1:0]    sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   localparam coef_t C [OSF][TAPS_PPH] = '{
      '{16'sd2048, 16'sd14336, 16'sd12288, 16'sd3072, 16'sd1024},
      '{16'sd2080, 16'sd14272, 16'sd12288, 16'sd3104, 16'sd1024},
      '{16'sd2112, 16'sd14208, 16'sd12288, 16'sd3136, 16'sd1024},
      '{16'sd2144, 16'sd14144, 16'sd12288, 16'sd3168, 16'sd1024},
      '{16'sd2176, 16'sd14080, 16'sd12288, 16'sd3200, 16'sd1024},
      '{16'sd2208, 16'sd14016, 16'sd12288, 16'sd3232, 16'sd1024},
      '{16'sd2240, 16'sd13952, 16'sd12288, 16'sd3264, 16'sd1024},
      '{16'sd2272, 16'sd13888, 16'sd12288, 16'sd3296, 16'sd1024},
      '{16'sd2304, 16'sd13824, 16'sd12288, 16'sd3328, 16'sd1024},
      '{16'sd2336, 16'sd13760, 16'sd12288, 16'sd3360, 16'sd1024},
      '{16'sd2368, 16'sd13696, 16'sd12288, 16'sd3392, 16'sd1024},
      '{16'sd2400, 16'sd13632, 16'sd12288, 16'sd3424, 16'sd1024},
      '{16'sd2432, 16'sd13568, 16'sd12288, 16'sd3456, 16'sd1024},
      '{16'sd2464, 16'sd13504, 16'sd12288, 16'sd3488, 16'sd1024},
      '{16'sd2496, 16'sd13440, 16'sd12288, 16'sd3520, 16'sd1024},
      '{16'sd2528, 16'sd13376, 16'sd12288, 16'sd3552, 16'sd1024},
      '{16'sd2560, 16'sd13312, 16'sd12288, 16'sd3584, 16'sd1024},
      '{16'sd2592, 16'sd13248, 16'sd12288, 16'sd3616, 16'sd1024},
      '{16'sd2624, 16'sd13184, 16'sd12288, 16'sd3648, 16'sd1024},
      '{16'sd2656, 16'sd13120, 16'sd12288, 16'sd3680, 16'sd1024}
   };

   localparam acc_t ACC_RND = acc_t'(1) <<< (COEF_W - 2);
   localparam acc_t SAT_HI  = acc_t'((1 <<< (WO - 1)) - 1);
   localparam acc_t SAT_LO  = -SAT_HI - acc_t'(1);

   // Round half up, drop the Q1.15 fraction, clamp to the output range.
   function automatic logic signed [WO-1:0] sat_round(input acc_t a);
      acc_t r;
      r = (a + ACC_RND) >>> (COEF_W - 1);
      if (r > SAT_HI)      return SAT_HI[WO-1:0];
      else if (r < SAT_LO) return SAT_LO[WO-1:0];
      else                 return r[WO-1:0];
   endfunction

endpackage

// File: rtl/interp_sample_ram.sv
// DEPTH x WIQ simple dual-port sample buffer with a registered read port.
// Cleared on reset so never-written locations read as zero.
module interp_sample_ram
   import interp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [WIQ-1:0]   wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [WIQ-1:0]   rdata_o
);

   logic [WIQ-1:0] mem_q [DEPTH];
   logic [WIQ-1:0] rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rdata_q <= '0;
      end else begin
         if (we_i) mem_q[waddr_i] <= wdata_i;
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/polyphase_interp_pipe.sv
// Polyphase fractional-delay I/Q interpolator: one filtered (or bypassed) sample pair per
// symbol strobe, computed with one MAC per channel over TAPS_PPH cycles.
module polyphase_interp_pipe
   import interp_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [WIQ-1:0] i_raw_i,
   input  logic [WIQ-1:0] q_raw_i,
   input  logic          iq_raw_val_i,
   input  logic [4:0]    phase_int_i,
   input  logic          sym_valid_i,
   input  logic          bypass_i,
   input  logic          clr_stat_i,
   output logic [WO-1:0] i_sym_o,
   output logic [WO-1:0] q_sym_o,
   output logic          sym_valid_o,
   output logic          busy_o,
   output logic          overrun_o,
   output logic          phase_err_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_MAC, ST_OUT} state_e;

   state_e           state_q, state_d;
   logic [1:0]       rst_sync_q;
   logic             rst_n_s;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d, raddr;
   logic [4:0]       phase_q, phase_d;
   logic [TAP_W-1:0] tap_q, tap_d, rd_tap;
   logic             byp_q, byp_d;
   acc_t             acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [WIQ-1:0]   byp_i_q, byp_i_d, byp_q_q, byp_q_d;
   logic [WO-1:0]    i_sym_q, i_sym_d, q_sym_q, q_sym_d;
   logic             sym_val_q, sym_val_d, ovr_q, ovr_d, perr_q, perr_d;
   logic [WIQ-1:0]   rd_i, rd_q;
   logic [PTR_W-1:0] age;
   logic [PTR_W:0]   addr_sum;
   logic             strobe_ok, bad_phase;
   coef_t            coef;

   // Reset asserts immediately, releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_s = rst_sync_q[1];

   interp_sample_ram u_ram_i (
      .clk(clk), .rst_n(rst_n_s), .we_i(iq_raw_val_i), .waddr_i(wr_ptr_q),
      .wdata_i(i_raw_i), .raddr_i(raddr), .rdata_o(rd_i)
   );

   interp_sample_ram u_ram_q (
      .clk(clk), .rst_n(rst_n_s), .we_i(iq_raw_val_i), .waddr_i(wr_ptr_q),
      .wdata_i(q_raw_i), .raddr_i(raddr), .rdata_o(rd_q)
   );

   // Tap k reads age p + k*OSF, newest sample sits at base-1; RD issues tap 0, MAC k issues k+1.
   always_comb begin
      rd_tap   = (state_q == ST_RD) ? '0 : TAP_W'(tap_q + 1'b1);
      age      = PTR_W'(phase_q) + PTR_W'(rd_tap) * PTR_W'(OSF);
      addr_sum = {1'b0, base_q} + (PTR_W+1)'(DEPTH - 1) - {1'b0, age};
      if (addr_sum >= (PTR_W+1)'(DEPTH)) addr_sum = addr_sum - (PTR_W+1)'(DEPTH);
      raddr    = addr_sum[PTR_W-1:0];
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      base_d    = base_q;
      phase_d   = phase_q;
      tap_d     = tap_q;
      byp_d     = byp_q;
      acc_i_d   = acc_i_q;
      acc_q_d   = acc_q_q;
      byp_i_d   = byp_i_q;
      byp_q_d   = byp_q_q;
      i_sym_d   = i_sym_q;
      q_sym_d   = q_sym_q;
      sym_val_d = 1'b0;
      coef      = C[phase_q][tap_q];
      strobe_ok = sym_valid_i && (state_q == ST_IDLE);
      bad_phase = phase_int_i >= 5'(OSF);

      if (iq_raw_val_i)
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(wr_ptr_q + 1'b1);

      case (state_q)
         ST_IDLE: begin
            if (sym_valid_i) begin
               state_d = ST_RD;
               phase_d = bad_phase ? 5'(OSF - 1) : phase_int_i;
               base_d  = wr_ptr_q;
               byp_d   = bypass_i;
               tap_d   = '0;
               acc_i_d = '0;
               acc_q_d = '0;
            end
         end
         ST_RD: state_d = ST_MAC;
         ST_MAC: begin
            acc_i_d = acc_i_q + acc_t'(sample_t'(rd_i)) * acc_t'(coef);
            acc_q_d = acc_q_q + acc_t'(sample_t'(rd_q)) * acc_t'(coef);
            if (tap_q == '0) begin
               byp_i_d = rd_i;
               byp_q_d = rd_q;
            end
            if (tap_q == TAP_W'(TAPS_PPH - 1)) state_d = ST_OUT;
            else                               tap_d   = TAP_W'(tap_q + 1'b1);
         end
         ST_OUT: begin
            state_d   = ST_IDLE;
            sym_val_d = 1'b1;
            if (byp_q) begin
               i_sym_d = {{(WO-WIQ){byp_i_q[WIQ-1]}}, byp_i_q};
               q_sym_d = {{(WO-WIQ){byp_q_q[WIQ-1]}}, byp_q_q};
            end else begin
               i_sym_d = sat_round(acc_i_q);
               q_sym_d = sat_round(acc_q_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (sym_valid_i && state_q != ST_IDLE) ovr_d = 1'b1;
      else if (clr_stat_i)                   ovr_d = 1'b0;
      else                                   ovr_d = ovr_q;

      if (strobe_ok && bad_phase) perr_d = 1'b1;
      else if (clr_stat_i)        perr_d = 1'b0;
      else                        perr_d = perr_q;
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         base_q    <= '0;
         phase_q   <= '0;
         tap_q     <= '0;
         byp_q     <= 1'b0;
         acc_i_q   <= '0;
         acc_q_q   <= '0;
         byp_i_q   <= '0;
         byp_q_q   <= '0;
         i_sym_q   <= '0;
         q_sym_q   <= '0;
         sym_val_q <= 1'b0;
         ovr_q     <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         base_q    <= base_d;
         phase_q   <= phase_d;
         tap_q     <= tap_d;
         byp_q     <= byp_d;
         acc_i_q   <= acc_i_d;
         acc_q_q   <= acc_q_d;
         byp_i_q   <= byp_i_d;
         byp_q_q   <= byp_q_d;
         i_sym_q   <= i_sym_d;
         q_sym_q   <= q_sym_d;
         sym_val_q <= sym_val_d;
         ovr_q     <= ovr_d;
         perr_q    <= perr_d;
      end
   end

   assign i_sym_o     = i_sym_q;
   assign q_sym_o     = q_sym_q;
   assign sym_valid_o = sym_val_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign overrun_o   = ovr_q;
   assign phase_err_o = perr_q;

endmodule

// File: tb/tb_polyphase_interp_pipe.sv
// Directed bench for polyphase_interp_pipe: impulse, DC, overrun, bad phase, reset abort, bypass.
module tb_polyphase_interp_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] i_raw_i, q_raw_i;
   logic        iq_raw_val_i;
   logic [4:0]  phase_int_i;
   logic        sym_valid_i, bypass_i, clr_stat_i;
   logic [17:0] i_sym_o, q_sym_o;
   logic        sym_valid_o, busy_o, overrun_o, phase_err_o;

   int checks = 0;
   int errors = 0;

   polyphase_interp_pipe dut (
      .clk(clk), .rst_n(rst_n), .i_raw_i(i_raw_i), .q_raw_i(q_raw_i),
      .iq_raw_val_i(iq_raw_val_i), .phase_int_i(phase_int_i), .sym_valid_i(sym_valid_i),
      .bypass_i(bypass_i), .clr_stat_i(clr_stat_i), .i_sym_o(i_sym_o), .q_sym_o(q_sym_o),
      .sym_valid_o(sym_valid_o), .busy_o(busy_o), .overrun_o(overrun_o),
      .phase_err_o(phase_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called and returns at 1 time unit after a rising edge.
   task automatic wr(input logic [15:0] vi, input logic [15:0] vq);
      i_raw_i = vi; q_raw_i = vq; iq_raw_val_i = 1'b1;
      @(posedge clk); #1;
      iq_raw_val_i = 1'b0;
   endtask

   task automatic do_strobe(input logic [4:0] p, input logic byp, input logic clr,
                            output logic signed [31:0] yi, output logic signed [31:0] yq);
      int lat;
      phase_int_i = p; bypass_i = byp; clr_stat_i = clr; sym_valid_i = 1'b1;
      @(posedge clk); #1;
      sym_valid_i = 1'b0; clr_stat_i = 1'b0;
      chk("busy_after_strobe", busy_o, 1);
      lat = 0;
      while (sym_valid_o !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      // Output strobe lands in strobe cycle + 8, i.e. 7 edges after the sampling edge.
      chk("latency", lat, 7);
      yi = $signed(i_sym_o);
      yq = $signed(q_sym_o);
      @(posedge clk); #1;
      chk("strobe_width", sym_valid_o, 0);
      chk("idle_after_out", busy_o, 0);
   endtask

   initial begin
      logic signed [31:0] yi, yq;
      int pulses;
      rst_n = 1'b0; i_raw_i = '0; q_raw_i = '0; iq_raw_val_i = 1'b0;
      phase_int_i = '0; sym_valid_i = 1'b0; bypass_i = 1'b0; clr_stat_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_i_sym", $signed(i_sym_o), 0);
      chk("rst_sym_valid", sym_valid_o, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q_sym", $signed(q_sym_o), 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_overrun", overrun_o, 0);
      chk("rst_phase_err", phase_err_o, 0);

      // Impulse at age 23, p=3 -> tap 1: round(1000*14144/32768) = 432
      wr(16'd1000, 16'd0);
      repeat (23) wr(16'd0, 16'd0);
      do_strobe(5'd3, 1'b0, 1'b0, yi, yq);
      chk("impulse_i", yi, 432);
      chk("impulse_q", yq, 0);

      // DC gain is exactly one on every branch
      repeat (200) wr(16'd12000, 16'd12000);
      for (int p = 0; p < 20; p++) begin
         do_strobe(5'(p), 1'b0, 1'b0, yi, yq);
         chk("dc_i", yi, 12000);
         chk("dc_q", yq, 12000);
      end
      repeat (200) wr(16'h7fff, 16'h8000);
      for (int p = 0; p < 20; p += 9) begin
         do_strobe(5'(p), 1'b0, 1'b0, yi, yq);
         chk("dc_max_i", yi, 32767);
         chk("dc_min_q", yq, -32768);
      end

      // Overrun: second strobe two cycles after the first
      chk("overrun_before", overrun_o, 0);
      phase_int_i = 5'd4; sym_valid_i = 1'b1;
      @(posedge clk); #1;
      sym_valid_i = 1'b0;
      @(posedge clk); #1;
      sym_valid_i = 1'b1;
      @(posedge clk); #1;
      sym_valid_i = 1'b0;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (sym_valid_o === 1'b1) pulses++;
      end
      chk("overrun_pulses", pulses, 1);
      chk("overrun_set", overrun_o, 1);
      clr_stat_i = 1'b1;
      @(posedge clk); #1;
      clr_stat_i = 1'b0;
      chk("overrun_cleared", overrun_o, 0);

      // Out-of-range phase clamps to branch 19; impulse at age 19 -> tap 0 coefficient 2656
      repeat (120) wr(16'd0, 16'd0);
      wr(16'd1000, 16'hfc18);
      repeat (19) wr(16'd0, 16'd0);
      do_strobe(5'd19, 1'b0, 1'b0, yi, yq);
      chk("p19_i", yi, 81);
      chk("p19_q", yq, -81);
      chk("p19_no_phase_err", phase_err_o, 0);
      do_strobe(5'd25, 1'b0, 1'b1, yi, yq);
      chk("p25_i", yi, 81);
      chk("p25_q", yq, -81);
      chk("phase_err_set_beats_clr", phase_err_o, 1);

      // Reset during MAC cycle 2 aborts the symbol
      phase_int_i = 5'd5; sym_valid_i = 1'b1;
      @(posedge clk); #1;
      sym_valid_i = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_i_sym", $signed(i_sym_o), 0);
      chk("abort_q_sym", $signed(q_sym_o), 0);
      chk("abort_phase_err", phase_err_o, 0);
      @(negedge clk) rst_n = 1'b1;
      pulses = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (sym_valid_o === 1'b1) pulses++;
      end
      chk("abort_no_strobe", pulses, 0);
      repeat (100) wr(16'd5000, 16'(-5000));
      do_strobe(5'd19, 1'b0, 1'b0, yi, yq);
      chk("post_reset_i", yi, 5000);
      chk("post_reset_q", yq, -5000);

      // Bypass: p=7 returns the sample written 8 writes before the strobe (n=22)
      for (int n = 0; n < 30; n++) wr(16'(-1000 + n * 37), 16'(n * 100));
      do_strobe(5'd7, 1'b1, 1'b0, yi, yq);
      chk("bypass_i", yi, -186);
      chk("bypass_q", yq, 2200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
